// File: rtl/if_stage_pkg.sv
// Shared fetch/decode definitions: NOP encoding, PC step, instruction field layout, opcodes.
// No logic; constants and small field-extraction helpers only.
// Imported by the fetch stage and by the decode controller so both agree on the encoding.
package if_stage_pkg;

  // Architectural constants
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Instruction field bit positions (decode owns the meaning, fetch just carries words)
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int SRC1_MSB = 25;
  localparam int SRC1_LSB = 21;
  localparam int SRC2_MSB = 20;
  localparam int SRC2_LSB = 16;
  localparam int RDST_MSB = 15;
  localparam int RDST_LSB = 11;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  // Opcode values understood by decode; 0 doubles as NOP when the whole word is zero
  typedef enum logic [5:0] {
    OP_NOP  = 6'h00,
    OP_ADDI = 6'h01,
    OP_ADD  = 6'h02,
    OP_SUB  = 6'h03,
    OP_LD   = 6'h04,
    OP_ST   = 6'h05,
    OP_BEQ  = 6'h06,
    OP_JMP  = 6'h07
  } opcode_e;

  // Field extraction helpers shared with decode
  function automatic logic [5:0] instr_opcode(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [4:0] instr_src1(input logic [31:0] instr);
    return instr[SRC1_MSB:SRC1_LSB];
  endfunction

  function automatic logic [4:0] instr_src2(input logic [31:0] instr);
    return instr[SRC2_MSB:SRC2_LSB];
  endfunction

  function automatic logic [4:0] instr_rdst(input logic [31:0] instr);
    return instr[RDST_MSB:RDST_LSB];
  endfunction

  function automatic logic [15:0] instr_imm(input logic [31:0] instr);
    return instr[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage control/program/IF-ID bundle between hazard/EXE/boot logic and if_stage.
// Pure wiring, no latency.
// No handshake: freeze is the only backpressure and is applied inside the stage.
interface if_stage_if #(
  parameter int IMEM_AW = 6
);
  // Control from hazard unit and EXE
  logic               freeze;
  logic               branch_taken;
  logic [31:0]        branch_addr;
  // Instruction memory load port
  logic               prog_we;
  logic [IMEM_AW-1:0] prog_addr;
  logic [31:0]        prog_data;
  // Fetch outputs toward decode / trace
  logic [31:0]        pc;
  logic [31:0]        instr_out;
  logic [31:0]        pc_out;
  logic               flush_out;

  // Driver side: hazard unit, EXE redirect, boot loader; observes IF/ID
  modport master (
    output freeze, branch_taken, branch_addr, prog_we, prog_addr, prog_data,
    input  pc, instr_out, pc_out, flush_out
  );

  // Fetch stage side
  modport slave (
    input  freeze, branch_taken, branch_addr, prog_we, prog_addr, prog_data,
    output pc, instr_out, pc_out, flush_out
  );
endinterface

// File: rtl/if_stage_imem.sv
// Instruction memory: IMEM_WORDS x 32, one synchronous write port, one async read port.
// Read is combinational (0 cycles); write lands at the posedge with i_we high.
// No backpressure; a same-cycle write to the read index is seen only after the edge.
module if_imem #(
  parameter int IMEM_WORDS = 64,
  parameter int IMEM_AW    = 6
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [IMEM_AW-1:0] i_waddr,
  input  logic [31:0]        i_wdata,
  input  logic [IMEM_AW-1:0] i_raddr,
  output logic [31:0]        o_rdata
);

  logic [31:0] r_mem [IMEM_WORDS];

  // Program load: contents survive reset, so no reset branch here
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC priority mux, IF/ID pipeline register.
// Word at PC p appears on instr_out 1 cycle after pc==p; a redirect costs one bubble.
// freeze holds PC and IF/ID; branch_taken overrides freeze; rst overrides everything.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int IMEM_AW    = 6
) (
  input  logic         clk,
  input  logic         rst,
  if_stage_if.slave    fe
);

  logic [31:0]        r_pc;
  logic [31:0]        r_instr;
  logic [31:0]        r_pc_out;
  logic               r_flush;

  logic [IMEM_AW-1:0] w_fetch_idx;
  logic [31:0]        w_imem_rdata;
  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_next_pc;
  logic [31:0]        w_next_instr;
  logic [31:0]        w_next_pc_out;
  logic               w_next_flush;

  // Upper PC bits are ignored, so fetch wraps modulo the memory depth
  assign w_fetch_idx = r_pc[IMEM_AW+1:2];
  assign w_pc_plus4  = r_pc + PC_STEP;

  if_imem #(
    .IMEM_WORDS (IMEM_WORDS),
    .IMEM_AW    (IMEM_AW)
  ) u_imem (
    .clk     (clk),
    .i_we    (fe.prog_we),
    .i_waddr (fe.prog_addr),
    .i_wdata (fe.prog_data),
    .i_raddr (w_fetch_idx),
    .o_rdata (w_imem_rdata)
  );

  // Next-PC and IF/ID priority: redirect > freeze > advance (reset handled in the register)
  always_comb begin
    w_next_pc      = w_pc_plus4;
    w_next_instr   = w_imem_rdata;
    w_next_pc_out  = w_pc_plus4;
    w_next_flush   = 1'b0;
    if (fe.branch_taken) begin
      // Targets are word aligned; stray low bits from EXE are discarded
      w_next_pc     = {fe.branch_addr[31:2], 2'b00};
      w_next_instr  = NOP_INSTR;
      w_next_pc_out = 32'd0;
      w_next_flush  = 1'b1;
    end else if (fe.freeze) begin
      w_next_pc     = r_pc;
      w_next_instr  = r_instr;
      w_next_pc_out = r_pc_out;
      w_next_flush  = r_flush;
    end
  end

  // PC and IF/ID state with synchronous reset taking precedence
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= 32'd0;
      r_instr  <= NOP_INSTR;
      r_pc_out <= 32'd0;
      r_flush  <= 1'b0;
    end else begin
      r_pc     <= w_next_pc;
      r_instr  <= w_next_instr;
      r_pc_out <= w_next_pc_out;
      r_flush  <= w_next_flush;
    end
  end

  assign fe.pc        = r_pc;
  assign fe.instr_out = r_instr;
  assign fe.pc_out    = r_pc_out;
  assign fe.flush_out = r_flush;

endmodule
